// File: rtl/board_pkg.sv
// -----------------------------------------------------------------------------
// board_pkg
// Shared types and constants for the 8x8 board display path (cursor
// controller, rectangle generator, game logic).
//   GRID_N       : board edge length in cells
//   coord_t      : cell coordinate (column or row), 0..7
//   dir_t        : cursor move direction, also used as the index of the
//                  per-direction button/step vectors
//   rpt_state_t  : per-direction auto-repeat FSM state
//   sel_state_t  : select-event handshake FSM state
// -----------------------------------------------------------------------------
package board_pkg;

    localparam int GRID_N = 8;

    typedef logic [2:0] coord_t;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RPT  = 2'd2
    } rpt_state_t;

    typedef enum logic {
        SIDLE = 1'b0,
        SPEND = 1'b1
    } sel_state_t;

endpackage : board_pkg

// File: rtl/board_cursor_if.sv
// -----------------------------------------------------------------------------
// board_cursor_if
// Valid/ready channel carrying the "cell selected" event from the cursor
// controller to the game logic.
//   sel_valid : event pending (producer -> consumer)
//   sel_x     : captured column, stable while sel_valid is 1
//   sel_y     : captured row, stable while sel_valid is 1
//   sel_ready : consumer accepts the event (consumer -> producer)
// Modports: master = event producer (board_cursor), slave = consumer.
// -----------------------------------------------------------------------------
interface board_cursor_if;
    import board_pkg::*;

    logic   sel_valid;
    coord_t sel_x;
    coord_t sel_y;
    logic   sel_ready;

    modport master (
        output sel_valid,
        output sel_x,
        output sel_y,
        input  sel_ready
    );

    modport slave (
        input  sel_valid,
        input  sel_x,
        input  sel_y,
        output sel_ready
    );

endinterface : board_cursor_if

// File: rtl/board_cursor_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Conditions one raw asynchronous push-button: 2-flop synchronizer, then a
// counter that accepts a new level only after DEBOUNCE_CYCLES consecutive
// samples that disagree with the current level. Any agreeing sample in
// between reloads the counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_raw    : raw active-high button
//   level      : debounced level (registered)
//   press      : one-cycle pulse, asserted in the first cycle level reads 1
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;

    // Synchronizer, debounce counter, level and press-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            press_r <= 1'b0;
            cnt_r   <= '0;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
            if (sync2_r != level_r) begin
                if (cnt_r == CNT_LAST) begin
                    // Last disagreeing sample: flip level; pulse only on 0->1.
                    level_r <= sync2_r;
                    press_r <= sync2_r;
                    cnt_r   <= '0;
                end else begin
                    press_r <= 1'b0;
                    cnt_r   <= cnt_r + CNT_W'(1);
                end
            end else begin
                press_r <= 1'b0;
                cnt_r   <= '0;
            end
        end
    end

    assign level = level_r;
    assign press = press_r;

endmodule : btn_debounce

// File: rtl/board_cursor.sv
// -----------------------------------------------------------------------------
// board_cursor
// Cursor/selection controller for the 8x8 board display. Five raw buttons
// are debounced; up/down/left/right move the cursor modulo 8, select emits a
// valid/ready "cell selected" event carrying the cursor cell at press time.
//   clk, rst_n                  : pixel clock, asynchronous active-low reset
//   btn_up/down/left/right/sel  : raw asynchronous active-high buttons
//   pos_x, pos_y                : registered cursor column/row
//   sel (board_cursor_if.master): sel_valid/sel_x/sel_y out, sel_ready in
// Configuration macro BOARD_CURSOR_AUTOREPEAT_EN: when defined, each
// direction auto-repeats (first repeat REPEAT_DELAY cycles after the press,
// then every REPEAT_RATE cycles); when undefined, one step per press.
// -----------------------------------------------------------------------------
module board_cursor
    import board_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_RATE     = 3125000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                btn_up,
    input  logic                btn_down,
    input  logic                btn_left,
    input  logic                btn_right,
    input  logic                btn_sel,
    output coord_t              pos_x,
    output coord_t              pos_y,
    board_cursor_if.master      sel
);

    logic [3:0] raw_s;
    logic [3:0] lvl_s;
    logic [3:0] press_s;
    logic [3:0] step_s;
    logic       sel_press_s;
    logic       unused_sel_level_s;

    coord_t     pos_x_r;
    coord_t     pos_y_r;
    coord_t     sel_x_r;
    coord_t     sel_y_r;
    logic       sel_valid_r;
    sel_state_t sel_state_r;

    assign raw_s[UP]    = btn_up;
    assign raw_s[DOWN]  = btn_down;
    assign raw_s[LEFT]  = btn_left;
    assign raw_s[RIGHT] = btn_right;

    for (genvar d = 0; d < 4; d++) begin : g_dir_db
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk     (clk),
            .rst_n   (rst_n),
            .btn_raw (raw_s[d]),
            .level   (lvl_s[d]),
            .press   (press_s[d])
        );
    end

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sel (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_sel),
        .level   (unused_sel_level_s),
        .press   (sel_press_s)
    );

`ifdef BOARD_CURSOR_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX + 1) : 1;
    localparam logic [RPT_W-1:0] DELAY_CNT = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RATE_CNT  = RPT_W'(REPEAT_RATE);

    for (genvar d = 0; d < 4; d++) begin : g_rpt
        rpt_state_t       state_r;
        logic [RPT_W-1:0] cnt_r;   // cycles since press (HOLD) / last step (RPT)

        // Per-direction auto-repeat FSM; cnt_r reads 1 in the cycle after a step.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_r <= IDLE;
                cnt_r   <= '0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (press_s[d]) begin
                            state_r <= HOLD;
                            cnt_r   <= RPT_W'(1);
                        end else begin
                            cnt_r   <= '0;
                        end
                    end
                    HOLD: begin
                        if (!lvl_s[d]) begin
                            state_r <= IDLE;
                            cnt_r   <= '0;
                        end else if (cnt_r == DELAY_CNT) begin
                            state_r <= RPT;
                            cnt_r   <= RPT_W'(1);
                        end else begin
                            cnt_r   <= cnt_r + RPT_W'(1);
                        end
                    end
                    RPT: begin
                        if (!lvl_s[d]) begin
                            state_r <= IDLE;
                            cnt_r   <= '0;
                        end else if (cnt_r == RATE_CNT) begin
                            cnt_r   <= RPT_W'(1);
                        end else begin
                            cnt_r   <= cnt_r + RPT_W'(1);
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        cnt_r   <= '0;
                    end
                endcase
            end
        end

        assign step_s[d] = press_s[d]
                         | ((state_r == HOLD) && lvl_s[d] && (cnt_r == DELAY_CNT))
                         | ((state_r == RPT)  && lvl_s[d] && (cnt_r == RATE_CNT));
    end
`else
    logic unused_repeat_cfg_s;

    assign step_s              = press_s;
    assign unused_repeat_cfg_s = ^{lvl_s, REPEAT_DELAY[0], REPEAT_RATE[0]};
`endif

    // Cursor position: opposite steps on one axis cancel; 3-bit wrap gives modulo 8.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x_r <= 3'd0;
            pos_y_r <= 3'd0;
        end else begin
            case ({step_s[RIGHT], step_s[LEFT]})
                2'b01:   pos_x_r <= pos_x_r - 3'd1;
                2'b10:   pos_x_r <= pos_x_r + 3'd1;
                default: pos_x_r <= pos_x_r;
            endcase
            case ({step_s[DOWN], step_s[UP]})
                2'b01:   pos_y_r <= pos_y_r - 3'd1;
                2'b10:   pos_y_r <= pos_y_r + 3'd1;
                default: pos_y_r <= pos_y_r;
            endcase
        end
    end

    // Select handshake FSM; captures the pre-move cursor, drops presses while pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_state_r <= SIDLE;
            sel_valid_r <= 1'b0;
            sel_x_r     <= 3'd0;
            sel_y_r     <= 3'd0;
        end else begin
            case (sel_state_r)
                SIDLE: begin
                    if (sel_press_s) begin
                        sel_state_r <= SPEND;
                        sel_valid_r <= 1'b1;
                        sel_x_r     <= pos_x_r;
                        sel_y_r     <= pos_y_r;
                    end else begin
                        sel_valid_r <= 1'b0;
                    end
                end
                SPEND: begin
                    if (sel.sel_ready) begin
                        sel_state_r <= SIDLE;
                        sel_valid_r <= 1'b0;
                    end else begin
                        sel_valid_r <= 1'b1;
                    end
                end
                default: begin
                    sel_state_r <= SIDLE;
                    sel_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign pos_x         = pos_x_r;
    assign pos_y         = pos_y_r;
    assign sel.sel_valid = sel_valid_r;
    assign sel.sel_x     = sel_x_r;
    assign sel.sel_y     = sel_y_r;

endmodule : board_cursor

// File: tb/tb_board_cursor.sv
// -----------------------------------------------------------------------------
// tb_board_cursor
// Directed bench for board_cursor with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_RATE=8. Expected values are hand-computed; auto-repeat expectations
// follow BOARD_CURSOR_AUTOREPEAT_EN.
// -----------------------------------------------------------------------------
module tb_board_cursor;
    import board_pkg::*;

    localparam int B_UP    = 0;
    localparam int B_DOWN  = 1;
    localparam int B_LEFT  = 2;
    localparam int B_RIGHT = 3;
    localparam int B_SEL   = 4;

    logic       clk;
    logic       rst_n;
    logic [4:0] btn;
    coord_t     pos_x;
    coord_t     pos_y;

    int tests_run    = 0;
    int tests_failed = 0;

    board_cursor_if sel_if ();

    board_cursor #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_RATE     (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_up    (btn[B_UP]),
        .btn_down  (btn[B_DOWN]),
        .btn_left  (btn[B_LEFT]),
        .btn_right (btn[B_RIGHT]),
        .btn_sel   (btn[B_SEL]),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .sel       (sel_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int act, input int exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Press a button for 'hold' cycles (short enough to avoid auto-repeat), then settle.
    task automatic tap(input int idx, input int hold);
        btn[idx] = 1'b1;
        repeat (hold) tick();
        btn[idx] = 1'b0;
        repeat (12) tick();
    endtask

    // Cycles until the selected observable changes (0=pos_x,1=pos_y,2=sel_valid); -1 on timeout.
    task automatic wait_change(input int which, output int n);
        int start;
        int cur;
        start = (which == 0) ? int'(pos_x) : (which == 1) ? int'(pos_y) : int'(sel_if.sel_valid);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            cur = (which == 0) ? int'(pos_x) : (which == 1) ? int'(pos_y) : int'(sel_if.sel_valid);
            if (cur != start) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int y0;
        int nchg;
        int offs [$];
        int exp_offs [$];
        int exp_final;
        int prev;

        rst_n = 1'b0;
        btn   = 5'b0;
        sel_if.sel_ready = 1'b0;
        repeat (3) tick();
        check_eq("rst_pos_x", pos_x, 0);
        check_eq("rst_pos_y", pos_y, 0);
        check_eq("rst_sel_valid", sel_if.sel_valid, 0);
        check_eq("rst_sel_x", sel_if.sel_x, 0);
        check_eq("rst_sel_y", sel_if.sel_y, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // 1. glitches shorter than the debounce window are rejected
        for (int g = 0; g < 2; g++) begin
            btn[B_RIGHT] = 1'b1;
            repeat (3) tick();
            btn[B_RIGHT] = 1'b0;
            repeat (3) tick();
        end
        repeat (6) tick();
        check_eq("glitch_no_step", pos_x, 0);
        btn[B_RIGHT] = 1'b1;
        wait_change(0, n);
        check_eq("right_latency", n, 7);
        repeat (4) tick();
        btn[B_RIGHT] = 1'b0;
        repeat (12) tick();
        check_eq("right_one_step", pos_x, 1);

        // 2. wrap on both axes
        for (int i = 0; i < 6; i++) tap(B_RIGHT, 12);
        check_eq("x_at_7", pos_x, 7);
        tap(B_RIGHT, 12);
        check_eq("x_wrap_7_to_0", pos_x, 0);
        tap(B_UP, 12);
        check_eq("y_wrap_0_to_7", pos_y, 7);
        tap(B_DOWN, 12);
        check_eq("y_back_to_0", pos_y, 0);
        tap(B_LEFT, 12);
        check_eq("x_wrap_0_to_7", pos_x, 7);
        tap(B_RIGHT, 12);
        check_eq("x_back_to_0", pos_x, 0);

        // 3. hold down: record step times relative to the first step
`ifdef BOARD_CURSOR_AUTOREPEAT_EN
        exp_offs  = '{20, 28, 36, 44, 52};
        exp_final = 6;
`else
        exp_offs  = {};
        exp_final = 1;
`endif
        btn[B_DOWN] = 1'b1;
        wait_change(1, n);
        check_eq("hold_first_step_seen", (n > 0) ? 1 : 0, 1);
        prev = pos_y;
        for (int k = 1; k <= 80; k++) begin
            if (k == 50) btn[B_DOWN] = 1'b0;  // raw drop after press-relative t=50
            tick();
            if (int'(pos_y) != prev) begin
                offs.push_back(k);
                prev = pos_y;
            end
        end
        check_eq("hold_repeat_count", offs.size(), exp_offs.size());
        for (int i = 0; i < exp_offs.size() && i < offs.size(); i++)
            check_eq($sformatf("hold_step_%0d_time", i), offs[i], exp_offs[i]);
        check_eq("hold_final_y", pos_y, exp_final);

        // 4. opposite presses cancel; orthogonal presses give a diagonal
        y0 = pos_y;
        btn[B_UP]   = 1'b1;
        btn[B_DOWN] = 1'b1;
        repeat (12) tick();
        btn[B_UP]   = 1'b0;
        btn[B_DOWN] = 1'b0;
        repeat (12) tick();
        check_eq("updown_cancel_y", pos_y, y0);
        check_eq("updown_cancel_x", pos_x, 0);
        rst_n = 1'b0;
        tick();
        check_eq("rst2_pos_y", pos_y, 0);
        rst_n = 1'b1;
        tick();
        btn[B_UP]    = 1'b1;
        btn[B_RIGHT] = 1'b1;
        repeat (12) tick();
        btn[B_UP]    = 1'b0;
        btn[B_RIGHT] = 1'b0;
        repeat (12) tick();
        check_eq("diag_x", pos_x, 1);
        check_eq("diag_y", pos_y, 7);

        // 5. select handshake with back-pressure
        tap(B_RIGHT, 12);
        tap(B_RIGHT, 12);
        tap(B_UP, 12);
        tap(B_UP, 12);
        check_eq("pre_sel_x", pos_x, 3);
        check_eq("pre_sel_y", pos_y, 5);
        btn[B_SEL] = 1'b1;
        wait_change(2, n);
        check_eq("sel_latency", n, 7);
        btn[B_SEL] = 1'b0;
        check_eq("sel_x_cap", sel_if.sel_x, 3);
        check_eq("sel_y_cap", sel_if.sel_y, 5);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("sel_valid_held", sel_if.sel_valid, 1);
        end
        tap(B_RIGHT, 12);
        check_eq("move_in_spend_x", pos_x, 4);
        tap(B_SEL, 12);
        check_eq("spend_valid", sel_if.sel_valid, 1);
        check_eq("spend_sel_x", sel_if.sel_x, 3);
        check_eq("spend_sel_y", sel_if.sel_y, 5);
        sel_if.sel_ready = 1'b1;
        check_eq("valid_before_accept", sel_if.sel_valid, 1);
        tick();
        check_eq("valid_after_accept", sel_if.sel_valid, 0);
        sel_if.sel_ready = 1'b0;
        repeat (20) tick();
        check_eq("second_press_dropped", sel_if.sel_valid, 0);

        // 6. reset while pending and mid-repeat
        tap(B_SEL, 12);
        check_eq("pend_before_rst", sel_if.sel_valid, 1);
        btn[B_DOWN] = 1'b1;
        wait_change(1, n);
        check_eq("rst_hold_step_seen", (n > 0) ? 1 : 0, 1);
        repeat (25) tick();
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", sel_if.sel_valid, 0);
        check_eq("async_rst_x", pos_x, 0);
        check_eq("async_rst_y", pos_y, 0);
        tick();
        tick();
        rst_n = 1'b1;
        wait_change(1, n);
        check_eq("redebounce_latency", n, 7);
        check_eq("redebounce_y", pos_y, 1);
        check_eq("redebounce_valid", sel_if.sel_valid, 0);
        btn[B_DOWN] = 1'b0;
        repeat (10) tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_board_cursor
